fft_bfly_sequencer: RTL and testbench
=====================================

# fft_bfly_sequencer

Control and address-generation stage sitting directly upstream of `butterfly_unit` in the radix-2 decimation-in-time FFT datapath. It walks every stage and every butterfly of an in-place N-point FFT. For each butterfly it issues the read addresses of operands A and B to the sample RAM and the index of the twiddle factor to the twiddle ROM. It also emits the write-back addresses and enable, time-aligned with the butterfly outputs returning to the same RAM. Input samples are already bit-reversed in RAM when `start` arrives.

## Interface
- `N_LOG2`, default 10: log2 of FFT length; N = 2^N_LOG2; legal range 2..12.
- `RD_LAT`, default 1: sample-RAM/twiddle-ROM read latency in cycles.
- `BFLY_LAT`, default 1: `butterfly_unit` input-to-output latency in cycles.
- PIPE = RD_LAT + BFLY_LAT (derived, not a parameter).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin an FFT; sampled only in IDLE.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`, inclusive.
- `done`  out  1  one-cycle pulse after the final write-back of the final stage.
- `rd_en`  out  1  read strobe to sample RAM and twiddle ROM.
- `rd_addr_a`  out  N_LOG2  address of operand A.
- `rd_addr_b`  out  N_LOG2  address of operand B.
- `tw_idx`  out  N_LOG2-1  twiddle ROM index k, for W_N^k.
- `wr_en`  out  1  write strobe for butterfly results.
- `wr_addr_a`  out  N_LOG2  destination of A output.
- `wr_addr_b`  out  N_LOG2  destination of B output.
- `stage`  out  $clog2(N_LOG2)  current stage number s.

## Operation
- FSM states:
  - **IDLE**: `start` → RUN, with s = 0 and j = 0.
  - **RUN**: one butterfly per cycle, `rd_en` = 1. When j = N/2-1, go to DRAIN.
  - **DRAIN**: count PIPE cycles with `rd_en` = 0. At the end, go to RUN with s+1 and j = 0 if s < N_LOG2-1; otherwise go to DONE.
  - **DONE**: one cycle with `done` = 1, then IDLE.
- Butterfly j of stage s:
  - span = 2^s
  - pos = j & (span-1)
  - grp = j >> s
  - `rd_addr_a` = (grp << (s+1)) | pos
  - `rd_addr_b` = `rd_addr_a` + span
  - `tw_idx` = pos << (N_LOG2-1-s), truncated to N_LOG2-1 bits
- Write path: `wr_en`, `wr_addr_a` and `wr_addr_b` are `rd_en`, `rd_addr_a` and `rd_addr_b` delayed by exactly PIPE cycles through a shift pipeline.
- Address and index outputs hold their last value when `rd_en` / `wr_en` are low. Consumers must ignore them while the strobe is low.
- DRAIN guarantees no read-after-write hazard: the first read of stage s+1 issues the cycle after the last write of stage s.
- `start` while `busy` is ignored. It is not queued.
- `rst` asserted in any cycle: next cycle the FSM is in IDLE, all outputs are 0, and the write pipeline is flushed. No `wr_en` may emerge from pre-reset reads.
- `start` and `rst` in the same cycle: reset wins.

## Timing
- Reset values: `busy`, `done`, `rd_en`, `wr_en` = 0; all addresses, `tw_idx` and `stage` = 0.
- `start` accepted at cycle 0:
  - `busy` and the first `rd_en` are high at cycle 1.
  - Stage s RUN covers cycles 1 + s·(N/2+PIPE) through s·(N/2+PIPE) + N/2.
- Each stage lasts N/2 + PIPE cycles.
- `done` is high at cycle N_LOG2·(N/2+PIPE) + 1 and `busy` falls the cycle after.
- A new `start` is accepted the cycle `busy` is low, giving back-to-back FFTs with one idle cycle between them.
- Total latency from `start` to `done` is N_LOG2·(N/2+PIPE) + 1 cycles. For the defaults this is 10·514 + 1 = 5141.

## Test plan
- **Stage-0 addresses** (N_LOG2=3, RD_LAT=1, BFLY_LAT=1): `start` at cycle 0 → cycles 1-4 give (a,b,tw) = (0,1,0), (2,3,0), (4,5,0), (6,7,0); cycles 5-6 have `rd_en` = 0.
- **Stages 1-2** (same config):
  - Cycles 7-10 give (0,2,0), (1,3,2), (4,6,0), (5,7,2).
  - Cycles 13-16 give (0,4,0), (1,5,1), (2,6,2), (3,7,3).
  - `done` = 1 at cycle 19 only.
- **Write alignment:** `wr_en` high at cycles 3-6, 9-12 and 15-18, with `wr_addr` equal to `rd_addr` from two cycles earlier. The last write of each stage precedes the next stage's first read.
- **Reset mid-operation:** `rst` at cycle 8 → from cycle 9 all outputs are 0 and no `wr_en` appears. A fresh `start` then reproduces the stage-0 sequence exactly.
- **Ignored start:** `start` pulses at cycles 3 and 12 during a run → no change to the sequence; `done` still at cycle 19.
- **Default config** (N_LOG2=10): `start` → exactly 5120 `rd_en` cycles and 5120 `wr_en` cycles. Every address pair is unique within a stage and XORs to span. `done` occurs at cycle 5141.

Source files
------------

// File: rtl/fft_bfly_sequencer.sv
// Stage/butterfly walker for an in-place radix-2 DIT FFT: issues operand and twiddle
// read addresses, and write-back addresses delayed to line up with butterfly results.
module fft_bfly_sequencer #(
  parameter int N_LOG2   = 10,
  parameter int RD_LAT   = 1,
  parameter int BFLY_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      rd_en,
  output logic [N_LOG2-1:0]         rd_addr_a,
  output logic [N_LOG2-1:0]         rd_addr_b,
  output logic [N_LOG2-2:0]         tw_idx,
  output logic                      wr_en,
  output logic [N_LOG2-1:0]         wr_addr_a,
  output logic [N_LOG2-1:0]         wr_addr_b,
  output logic [$clog2(N_LOG2)-1:0] stage
);

  localparam int PIPE = RD_LAT + BFLY_LAT;
  localparam int SW   = $clog2(N_LOG2);
  localparam int CW   = (PIPE > 1) ? $clog2(PIPE) : 1;

  localparam logic [N_LOG2-2:0] J_LAST = '1;
  localparam logic [SW-1:0]     S_LAST = SW'(N_LOG2 - 1);
  localparam logic [CW-1:0]     C_LAST = CW'(PIPE - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic              en;
    logic [N_LOG2-1:0] a;
    logic [N_LOG2-1:0] b;
  } wr_slot_t;

  state_t                 state_q, state_d;
  logic [SW-1:0]          s_q, s_d;
  logic [N_LOG2-2:0]      j_q, j_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   rd_en_q, rd_en_d;
  logic [N_LOG2-1:0]      rd_addr_a_q, rd_addr_a_d;
  logic [N_LOG2-1:0]      rd_addr_b_q, rd_addr_b_d;
  logic [N_LOG2-2:0]      tw_idx_q, tw_idx_d;
  wr_slot_t [PIPE-1:0]    pipe_q, pipe_d;

  logic [N_LOG2-1:0] span, jx, pos, grp, addr_a, tw_full;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    j_d     = j_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          s_d     = '0;
          j_d     = '0;
        end
      end
      ST_RUN: begin
        if (j_q == J_LAST) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        // Hold off the next stage until the last write of this one has landed.
        if (cnt_q == C_LAST) begin
          if (s_q == S_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            s_d     = s_q + 1'b1;
            j_d     = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Addresses are computed from the next (s, j) so they are registered with rd_en.
  always_comb begin
    rd_en_d     = (state_d == ST_RUN);
    rd_addr_a_d = rd_addr_a_q;
    rd_addr_b_d = rd_addr_b_q;
    tw_idx_d    = tw_idx_q;
    span        = N_LOG2'(1) << s_d;
    jx          = N_LOG2'(j_d);
    pos         = jx & (span - 1'b1);
    grp         = jx >> s_d;
    addr_a      = (grp << (int'(s_d) + 1)) | pos;
    tw_full     = pos << (N_LOG2 - 1 - int'(s_d));
    if (rd_en_d) begin
      rd_addr_a_d = addr_a;
      rd_addr_b_d = addr_a + span;
      tw_idx_d    = tw_full[N_LOG2-2:0];
    end
  end

  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = {rd_en_q, rd_addr_a_q, rd_addr_b_q};
    for (int i = 1; i < PIPE; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      s_q         <= '0;
      j_q         <= '0;
      cnt_q       <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      tw_idx_q    <= '0;
      pipe_q      <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      j_q         <= j_d;
      cnt_q       <= cnt_d;
      rd_en_q     <= rd_en_d;
      rd_addr_a_q <= rd_addr_a_d;
      rd_addr_b_q <= rd_addr_b_d;
      tw_idx_q    <= tw_idx_d;
      pipe_q      <= pipe_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign rd_en     = rd_en_q;
  assign rd_addr_a = rd_addr_a_q;
  assign rd_addr_b = rd_addr_b_q;
  assign tw_idx    = tw_idx_q;
  assign wr_en     = pipe_q[PIPE-1].en;
  assign wr_addr_a = pipe_q[PIPE-1].a;
  assign wr_addr_b = pipe_q[PIPE-1].b;
  assign stage     = s_q;

endmodule

// File: tb/tb_fft_bfly_sequencer.sv
// Directed bench: 8-point instance checked cycle by cycle against hand tables,
// plus a default 1024-point instance checked for counts, pairing and latency.
module tb_fft_bfly_sequencer;

  logic clk = 1'b0;
  logic rst, start, start2;
  always #5 clk = ~clk;

  logic       busy, done, rd_en, wr_en;
  logic [2:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [1:0] tw_idx, stage;

  logic       busy2, done2, rd_en2, wr_en2;
  logic [9:0] rd_addr_a2, rd_addr_b2, wr_addr_a2, wr_addr_b2;
  logic [8:0] tw_idx2;
  logic [3:0] stage2;

  fft_bfly_sequencer #(.N_LOG2(3), .RD_LAT(1), .BFLY_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_idx(tw_idx),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b), .stage(stage)
  );

  fft_bfly_sequencer dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
    .rd_en(rd_en2), .rd_addr_a(rd_addr_a2), .rd_addr_b(rd_addr_b2), .tw_idx(tw_idx2),
    .wr_en(wr_en2), .wr_addr_a(wr_addr_a2), .wr_addr_b(wr_addr_b2), .stage(stage2)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  // Hand-computed butterfly table for N=8, stages 0..2, four butterflies each.
  int ea[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int eb[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int et[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // Start at cycle 0 and check cycles 1..20 of an 8-point run.
  task automatic run_fft(input bit extra_starts, input string tag);
    logic [3:0] exp_ctl, got_ctl;
    logic [9:0] exp_rd, got_rd;
    logic [5:0] exp_wr, got_wr;
    int off, st, ri, woff, wi;
    bit exp_rd_en, exp_wr_en;
    start = 1'b1;
    cyc   = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      start = (extra_starts && (cyc == 3 || cyc == 12)) ? 1'b1 : 1'b0;
      off  = (cyc - 1) % 6;
      st   = (cyc - 1) / 6;
      ri   = st * 4 + off;
      exp_rd_en = (cyc >= 1 && cyc <= 18 && off < 4);
      woff = (cyc >= 3) ? (cyc - 3) % 6 : 0;
      wi   = (cyc >= 3) ? ((cyc - 3) / 6) * 4 + woff : 0;
      exp_wr_en = (cyc >= 3 && cyc <= 18 && woff < 4);
      exp_ctl = {cyc <= 19, cyc == 19, exp_rd_en, exp_wr_en};
      got_ctl = {busy, done, rd_en, wr_en};
      checks++;
      if (got_ctl !== exp_ctl) begin
        fails++;
        $display("[TB] FAIL %s ctl cyc=%0d busy/done/rd/wr got=%b want=%b", tag, cyc, got_ctl, exp_ctl);
      end
      if (exp_rd_en) begin
        exp_rd = {3'(ea[ri]), 3'(eb[ri]), 2'(et[ri]), 2'(st)};
        got_rd = {rd_addr_a, rd_addr_b, tw_idx, stage};
        checks++;
        if (got_rd !== exp_rd) begin
          fails++;
          $display("[TB] FAIL %s rd cyc=%0d a=%0d b=%0d tw=%0d s=%0d want a=%0d b=%0d tw=%0d s=%0d",
                   tag, cyc, rd_addr_a, rd_addr_b, tw_idx, stage, ea[ri], eb[ri], et[ri], st);
        end
      end
      if (exp_wr_en) begin
        exp_wr = {3'(ea[wi]), 3'(eb[wi])};
        got_wr = {wr_addr_a, wr_addr_b};
        checks++;
        if (got_wr !== exp_wr) begin
          fails++;
          $display("[TB] FAIL %s wr cyc=%0d a=%0d b=%0d want a=%0d b=%0d",
                   tag, cyc, wr_addr_a, wr_addr_b, ea[wi], eb[wi]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start2 = 1'b0;
    step(); step();
    rst = 1'b0;
    checks++;
    if ({busy, done, rd_en, wr_en, rd_addr_a, rd_addr_b, tw_idx, wr_addr_a, wr_addr_b, stage} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_small outputs got busy=%b done=%b rd=%b wr=%b ra=%0d rb=%0d tw=%0d wa=%0d wb=%0d s=%0d want all 0",
               busy, done, rd_en, wr_en, rd_addr_a, rd_addr_b, tw_idx, wr_addr_a, wr_addr_b, stage);
    end
    checks++;
    if ({busy2, done2, rd_en2, wr_en2, rd_addr_a2, rd_addr_b2, tw_idx2, wr_addr_a2, wr_addr_b2, stage2} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_default outputs got busy=%b rd=%b wr=%b ra=%0d rb=%0d want all 0",
               busy2, rd_en2, wr_en2, rd_addr_a2, rd_addr_b2);
    end
    step();
  endtask

  task automatic test_stage_sequence();
    run_fft(1'b0, "sequence");
  endtask

  task automatic test_back_to_back();
    run_fft(1'b0, "back_to_back");
  endtask

  task automatic test_ignored_start();
    run_fft(1'b1, "ignored_start");
    step();
    checks++;
    if (busy !== 1'b0 || rd_en !== 1'b0) begin
      fails++;
      $display("[TB] FAIL ignored_start_queued got busy=%b rd=%b want 0 0", busy, rd_en);
    end
  endtask

  task automatic test_reset_mid();
    bit leak;
    start = 1'b1;
    cyc   = 0;
    while (cyc < 8) begin
      step();
      start = 1'b0;
    end
    checks++;
    if ({rd_en, rd_addr_a, rd_addr_b, tw_idx} !== {1'b1, 3'd1, 3'd3, 2'd2}) begin
      fails++;
      $display("[TB] FAIL reset_mid_pre cyc8 rd=%b a=%0d b=%0d tw=%0d want 1 1 3 2", rd_en, rd_addr_a, rd_addr_b, tw_idx);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({busy, done, rd_en, wr_en, rd_addr_a, rd_addr_b, tw_idx, wr_addr_a, wr_addr_b, stage} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_mid_zero cyc9 busy=%b rd=%b wr=%b ra=%0d rb=%0d tw=%0d wa=%0d wb=%0d s=%0d want all 0",
               busy, rd_en, wr_en, rd_addr_a, rd_addr_b, tw_idx, wr_addr_a, wr_addr_b, stage);
    end
    leak = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (wr_en !== 1'b0 || rd_en !== 1'b0 || busy !== 1'b0) leak = 1'b1;
    end
    checks++;
    if (leak) begin
      fails++;
      $display("[TB] FAIL reset_mid_leak got activity after reset=1 want 0");
    end
    run_fft(1'b0, "after_reset");
  endtask

  task automatic test_reset_start_same();
    step();
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || rd_en !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_vs_start got busy=%b rd=%b want 0 0", busy, rd_en);
    end
  endtask

  task automatic test_default_config();
    int rd_cnt, wr_cnt, done_cyc, xor_err, dup_err, stages_seen, cur_stage;
    bit busy_after;
    bit [1023:0] seen;
    rd_cnt = 0; wr_cnt = 0; done_cyc = -1; xor_err = 0; dup_err = 0;
    stages_seen = 0; cur_stage = -1; seen = '0; busy_after = 1'b1;
    start2 = 1'b1;
    cyc = 0;
    while (cyc < 5300) begin
      step();
      start2 = 1'b0;
      if (rd_en2) begin
        rd_cnt++;
        if (int'(stage2) != cur_stage) begin
          cur_stage = int'(stage2);
          stages_seen++;
          seen = '0;
        end
        if ((rd_addr_a2 ^ rd_addr_b2) !== (10'd1 << stage2)) xor_err++;
        if (seen[rd_addr_a2] || seen[rd_addr_b2]) dup_err++;
        seen[rd_addr_a2] = 1'b1;
        seen[rd_addr_b2] = 1'b1;
      end
      if (wr_en2) wr_cnt++;
      if (done2 && done_cyc < 0) done_cyc = cyc;
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        busy_after = busy2;
        break;
      end
    end
    checks++;
    if (rd_cnt != 5120) begin fails++; $display("[TB] FAIL default_rd_count got=%0d want=5120", rd_cnt); end
    checks++;
    if (wr_cnt != 5120) begin fails++; $display("[TB] FAIL default_wr_count got=%0d want=5120", wr_cnt); end
    checks++;
    if (done_cyc != 5141) begin fails++; $display("[TB] FAIL default_done_cycle got=%0d want=5141", done_cyc); end
    checks++;
    if (xor_err != 0) begin fails++; $display("[TB] FAIL default_pair_xor got %0d bad pairs want 0", xor_err); end
    checks++;
    if (dup_err != 0) begin fails++; $display("[TB] FAIL default_unique got %0d repeats want 0", dup_err); end
    checks++;
    if (stages_seen != 10) begin fails++; $display("[TB] FAIL default_stages got=%0d want=10", stages_seen); end
    checks++;
    if (busy_after !== 1'b0) begin fails++; $display("[TB] FAIL default_busy_fall got=%b want=0", busy_after); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start2 = 1'b0;
    test_reset();
    test_stage_sequence();
    test_back_to_back();
    test_ignored_start();
    test_reset_mid();
    test_reset_start_same();
    test_default_config();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
